jtag_frame_rx: RTL and testbench

// - Parametrised JTAG DR-scan receiver; sits behind a BSCANE2 USER chain and runs in the TCK domain.
// - Each scan carries an ADDR_W-bit start address followed by any number of DATA_W-bit words.
// - Completed words are pushed as {addr,data} into a FIFO_DEPTH-entry buffer drained via valid/ready.
// - A status word is returned on TDO, replacing the single-word ack handshake of the previous receiver.

---
 rtl/jtag_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_jtag_frame_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_frame_rx.sv
// JTAG DR-scan receiver: address + data-word frames into a small {addr,data} FIFO.
// A 16-bit status word {overflow, partial, wcount} is returned on TDO each scan.
module jtag_frame_rx #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sel_i,
    input  logic              capture_i,
    input  logic              shift_i,
    input  logic              update_i,
    input  logic              tap_reset_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CW    = $clog2(MAX_W);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = ADDR_W + DATA_W;

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     bitcnt;
    logic [ADDR_W-2:0] addr_sr;
    logic [DATA_W-2:0] data_sr;
    logic [ADDR_W-1:0] cur_addr;
    logic [13:0]       wcount;
    logic [15:0]       stat_sr;
    logic              overflow;
    logic              partial;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       count;

    logic capture_ev, update_ev, addr_shift, data_shift;
    logic addr_done, word_done, full, push, pop;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic [EW-1:0]     head;

    assign addr_next = {tdi_i, addr_sr};
    assign data_next = {tdi_i, data_sr};
    assign addr_done = addr_shift && (bitcnt == ADDR_LAST);
    assign word_done = data_shift && (bitcnt == DATA_LAST);

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign valid_o = (count != '0);
    assign push    = word_done && !full;
    assign pop     = valid_o && ready_i;
    assign head    = mem[rptr];

    // Outputs read as zero whenever the FIFO is empty, including after reset.
    assign addr_o     = valid_o ? head[EW-1:DATA_W] : '0;
    assign data_o     = valid_o ? head[DATA_W-1:0] : '0;
    assign tdo_o      = stat_sr[0];
    assign overflow_o = overflow;
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        capture_ev = 1'b0;
        update_ev  = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        if (tap_reset_i || !sel_i) begin
            state_d = IDLE;
        end else if (capture_i) begin
            state_d    = ADDR;
            capture_ev = 1'b1;
        end else if (update_i && state_q != IDLE) begin
            state_d   = IDLE;
            update_ev = 1'b1;
        end else if (shift_i) begin
            unique case (state_q)
                ADDR: begin
                    addr_shift = 1'b1;
                    if (bitcnt == ADDR_LAST) state_d = DATA;
                end
                DATA:    data_shift = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bitcnt   <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            cur_addr <= '0;
            wcount   <= '0;
            overflow <= 1'b0;
            partial  <= 1'b0;
        end else if (tap_reset_i) begin
            bitcnt   <= '0;
            wcount   <= '0;
            overflow <= 1'b0;
            partial  <= 1'b0;
        end else if (!sel_i) begin
            bitcnt <= '0;
        end else if (capture_ev) begin
            bitcnt <= '0;
            wcount <= '0;
        end else if (update_ev) begin
            bitcnt <= '0;
            if (bitcnt != '0) partial <= 1'b1;
        end else if (addr_shift) begin
            addr_sr <= addr_next[ADDR_W-1:1];
            if (addr_done) begin
                cur_addr <= addr_next;
                bitcnt   <= '0;
            end else begin
                bitcnt <= bitcnt + CW'(1);
            end
        end else if (data_shift) begin
            data_sr <= data_next[DATA_W-1:1];
            if (word_done) begin
                bitcnt   <= '0;
                cur_addr <= cur_addr + ADDR_W'(1);
                if (wcount != 14'h3FFF) wcount <= wcount + 14'd1;
                if (full) overflow <= 1'b1;
            end else begin
                bitcnt <= bitcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   stat_sr <= '0;
        else if (capture_ev)         stat_sr <= {overflow, partial, wcount};
        else if (sel_i && shift_i)   stat_sr <= {1'b0, stat_sr[15:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (!push && pop) count <= count - (PW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= {cur_addr, data_next};
    end

endmodule

// File: tb/tb_jtag_frame_rx.sv
// Directed bench for jtag_frame_rx: frames, FIFO ordering, overflow/partial status,
// address wrap, sel drop and asynchronous reset mid-frame.
module tb_jtag_frame_rx;

    logic        clk = 1'b0;
    logic        rst, sel, capture, shift, update, tap_reset, tdi;
    logic        tdo, valid, ready, overflow, busy;
    logic [14:0] addr;
    logic [31:0] data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ga, gd, junk;

    always #5 clk = ~clk;

    jtag_frame_rx dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .capture_i(capture),
        .shift_i(shift), .update_i(update), .tap_reset_i(tap_reset),
        .tdi_i(tdi), .tdo_o(tdo), .valid_o(valid), .ready_i(ready),
        .addr_o(addr), .data_o(data), .overflow_o(overflow), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic do_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Shift n bits of val LSB first; got collects tdo seen before each edge.
    task automatic shift_n(input logic [31:0] val, input int n,
                           input bit pop_last, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            tdi   = val[i];
            shift = 1'b1;
            if (pop_last && i == n - 1) ready = 1'b1;
            got[i] = tdo;
            tick();
            ready = 1'b0;
        end
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [14:0] a,
                           input logic [31:0] d);
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_addr"}, 64'(addr), 64'(a));
        check({tag, "_data"}, 64'(data), 64'(d));
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; capture = 1'b0; shift = 1'b0;
        update = 1'b0; tap_reset = 1'b0; tdi = 1'b0; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // clean frame
        sel = 1'b1;
        do_capture();
        check("clean_busy", 64'(busy), 64'd1);
        shift_n(32'h0010, 15, 1'b0, ga);
        shift_n(32'hDEADBEEF, 32, 1'b0, gd);
        check("clean_stat", 64'({gd[0], ga[14:0]}), 64'h0000);
        shift_n(32'h12345678, 32, 1'b0, junk);
        check("clean_busy_pre", 64'(busy), 64'd1);
        do_update();
        check("clean_busy_post", 64'(busy), 64'd0);
        pop_chk("clean0", 15'h0010, 32'hDEADBEEF);
        pop_chk("clean1", 15'h0011, 32'h12345678);
        check("clean_empty", 64'(valid), 64'd0);

        // address wrap
        do_capture();
        shift_n(32'h7FFF, 15, 1'b0, ga);
        shift_n(32'hA5A5A5A5, 32, 1'b0, gd);
        check("wrap_stat", 64'({gd[0], ga[14:0]}), 64'h0002);
        shift_n(32'h5A5A5A5A, 32, 1'b0, junk);
        do_update();
        pop_chk("wrap0", 15'h7FFF, 32'hA5A5A5A5);
        pop_chk("wrap1", 15'h0000, 32'h5A5A5A5A);

        // push and pop together at count=3
        do_capture();
        shift_n(32'h0100, 15, 1'b0, junk);
        shift_n(32'hC0000000, 32, 1'b0, junk);
        shift_n(32'hC0000001, 32, 1'b0, junk);
        shift_n(32'hC0000002, 32, 1'b0, junk);
        check("pp_head", 64'(data), 64'hC0000000);
        shift_n(32'hC0000003, 32, 1'b1, junk);
        do_update();
        pop_chk("pp1", 15'h0101, 32'hC0000001);
        pop_chk("pp2", 15'h0102, 32'hC0000002);
        pop_chk("pp3", 15'h0103, 32'hC0000003);
        check("pp_empty", 64'(valid), 64'd0);

        // overflow
        do_capture();
        shift_n(32'h0020, 15, 1'b0, ga);
        for (int w = 0; w < 6; w++) begin
            shift_n(32'hB0000000 + 32'(w), 32, 1'b0, gd);
            if (w == 0) check("ovf_prev_stat", 64'({gd[0], ga[14:0]}), 64'h0004);
        end
        do_update();
        check("ovf_flag", 64'(overflow), 64'd1);
        do_capture();
        shift_n(32'h0, 15, 1'b0, ga);
        shift_n(32'h0, 1, 1'b0, gd);
        check("ovf_stat", 64'({gd[0], ga[14:0]}), 64'h8006);
        do_update();
        for (int w = 0; w < 4; w++)
            pop_chk("ovf_pop", 15'h0020 + 15'(w), 32'hB0000000 + 32'(w));
        check("ovf_held4", 64'(valid), 64'd0);
        tap_reset = 1'b1;
        tick();
        tap_reset = 1'b0;
        check("tap_ovf_clr", 64'(overflow), 64'd0);

        // partial frame
        do_capture();
        shift_n(32'h0030, 15, 1'b0, ga);
        shift_n(32'hFFFFF, 20, 1'b0, gd);
        check("tap_stat", 64'({gd[0], ga[14:0]}), 64'h0000);
        do_update();
        check("part_nopush", 64'(valid), 64'd0);
        do_capture();
        shift_n(32'h0, 15, 1'b0, ga);
        shift_n(32'h0, 1, 1'b0, gd);
        check("part_stat", 64'({gd[0], ga[14:0]}), 64'h4000);
        do_update();

        // sel drop mid-word
        do_capture();
        shift_n(32'h0040, 15, 1'b0, junk);
        shift_n(32'h11111111, 32, 1'b0, junk);
        shift_n(32'h3FF, 10, 1'b0, junk);
        sel = 1'b0;
        tick();
        check("sel_busy", 64'(busy), 64'd0);
        check("sel_kept", 64'(data), 64'h11111111);
        sel = 1'b1;
        do_capture();
        shift_n(32'h0050, 15, 1'b0, junk);
        shift_n(32'h22222222, 32, 1'b0, junk);
        do_update();
        pop_chk("sel0", 15'h0040, 32'h11111111);
        pop_chk("sel1", 15'h0050, 32'h22222222);

        // async reset mid-DATA
        do_capture();
        shift_n(32'h0060, 15, 1'b0, junk);
        shift_n(32'h33333333, 32, 1'b0, junk);
        shift_n(32'h155, 10, 1'b0, junk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_data", 64'(data), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_tdo", 64'(tdo), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        do_capture();
        shift_n(32'h0070, 15, 1'b0, ga);
        shift_n(32'h44444444, 32, 1'b0, gd);
        check("arst_stat", 64'({gd[0], ga[14:0]}), 64'h0000);
        do_update();
        pop_chk("arst0", 15'h0070, 32'h44444444);
        check("arst_empty", 64'(valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
